// File: rtl/gf180mcu_fd_sc_mcu9t5v0_dlyprog_pkg.sv
// Shared helpers for the programmable delay line: select-width derivation
// and tap-request clamping.
package gf180mcu_fd_sc_mcu9t5v0_dlyprog_pkg;

  // Nominal number of stages when the block is used standalone.
  localparam int DEPTH_DFLT = 8;

  // Bits needed to encode every delay from 0 up to and including depth.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Requests beyond the last stage saturate to the deepest tap.
  function automatic int clamp_sel(input int req, input int max_sel);
    return (req > max_sel) ? max_sel : req;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_dlyprog_stage.sv
// One WIDTH-bit register of the delay chain: synchronous clear wins over
// the shift enable.
module gf180mcu_fd_sc_mcu9t5v0_dlyprog_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Clear to zero, otherwise load on enable, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0_dlyprog.sv
// Runtime-programmable WIDTH-bit delay line of 0..DEPTH cycles with a
// fill counter that flags when the selected tap holds real input history.
module gf180mcu_fd_sc_mcu9t5v0_dlyprog
  import gf180mcu_fd_sc_mcu9t5v0_dlyprog_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int DEPTH       = DEPTH_DFLT,
  parameter int DEFAULT_SEL = 1,
  parameter int SW          = sel_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [SW-1:0]    SEL_IN,
  output logic [SW-1:0]    SEL,
  output logic [WIDTH-1:0] Z,
  output logic             VALID
);

  localparam int SEL_CLAMP = DEPTH;

  logic [WIDTH-1:0] stage_q [1:DEPTH];
  logic [SW-1:0]    fill_q, fill_d;
  logic [SW-1:0]    sel_q, sel_d;

  // Stage 1 samples the input; every later stage samples its predecessor.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (k == 1) begin : g_first
      assign d = I;
    end else begin : g_next
      assign d = stage_q[k-1];
    end
    gf180mcu_fd_sc_mcu9t5v0_dlyprog_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk_i(CLK),
      .clr_i(RST),
      .en_i (EN),
      .d_i  (d),
      .q_o  (stage_q[k])
    );
  end

  // Fill count saturates at DEPTH; tap requests clamp to the deepest stage.
  always_comb begin
    fill_d = fill_q;
    sel_d  = sel_q;
    if (EN && (fill_q != SW'(DEPTH))) begin
      fill_d = fill_q + SW'(1);
    end
    if (LOAD) begin
      sel_d = SW'(clamp_sel(int'(SEL_IN), SEL_CLAMP));
    end
  end

  // Control registers; reset discards history and restores the default tap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_q <= '0;
      sel_q  <= SW'(DEFAULT_SEL);
    end else begin
      fill_q <= fill_d;
      sel_q  <= sel_d;
    end
  end

  // Tap mux: select 0 is a zero-latency bypass of the input.
  always_comb begin
    Z = I;
    for (int k = 1; k <= DEPTH; k++) begin
      if (sel_q == SW'(k)) begin
        Z = stage_q[k];
      end
    end
  end

  assign SEL   = sel_q;
  assign VALID = (fill_q >= sel_q);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_dlyprog.sv
// Bench for the programmable delay line: hand-computed vector table, then
// directed and random sequences checked against a sample-history model.
module tb_gf180mcu_fd_sc_mcu9t5v0_dlyprog;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int DSEL  = 1;
  localparam int SW    = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] I = '0;
  logic             EN = 1'b0;
  logic             LOAD = 1'b0;
  logic [SW-1:0]    SEL_IN = '0;
  logic [SW-1:0]    SEL;
  logic [WIDTH-1:0] Z;
  logic             VALID;

  gf180mcu_fd_sc_mcu9t5v0_dlyprog #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DEFAULT_SEL(DSEL)
  ) dut (
    .CLK(CLK), .RST(RST), .I(I), .EN(EN), .LOAD(LOAD),
    .SEL_IN(SEL_IN), .SEL(SEL), .Z(Z), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic             rst, en, load;
    logic [SW-1:0]    sel_in;
    logic [WIDTH-1:0] i;
    bit               chk;
    logic [WIDTH-1:0] z;
    logic             valid;
    logic [SW-1:0]    sel;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic             valid;
    logic [SW-1:0]    sel;
    string            nm;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] hist[$];
  int               m_fill;
  int               m_sel;
  int               total = 0;
  int               bad = 0;

  task automatic cmp(input string nm, input logic [WIDTH-1:0] got,
                     input logic [WIDTH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // One cycle: drive at negedge, push expectation, compare, advance model.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [SW-1:0] s, input logic [WIDTH-1:0] i,
                      input bit chk, input bit use_tbl,
                      input logic [WIDTH-1:0] tz, input logic tv,
                      input logic [SW-1:0] ts, input string nm);
    exp_t ex;
    @(negedge CLK);
    RST = r; EN = e; LOAD = l; SEL_IN = s; I = i;
    #1;
    if (chk) begin
      if (use_tbl) begin
        ex.z = tz; ex.valid = tv; ex.sel = ts;
      end else begin
        ex.z     = (m_sel == 0) ? i : hist[m_sel-1];
        ex.valid = (m_fill >= m_sel);
        ex.sel   = SW'(m_sel);
      end
      ex.nm = nm;
      sb.push_back(ex);
    end
    if (sb.size() > 0) begin
      ex = sb.pop_front();
      cmp({ex.nm, " Z"}, Z, ex.z);
      cmp({ex.nm, " VALID"}, {3'b0, VALID}, {3'b0, ex.valid});
      cmp({ex.nm, " SEL"}, SEL, ex.sel);
    end
    @(posedge CLK);
    if (r) begin
      hist.delete();
      for (int k = 0; k < DEPTH; k++) hist.push_back('0);
      m_fill = 0;
      m_sel  = DSEL;
    end else begin
      if (e) begin
        hist.push_front(i);
        void'(hist.pop_back());
        if (m_fill < DEPTH) m_fill++;
      end
      if (l) m_sel = (int'(s) > DEPTH) ? DEPTH : int'(s);
    end
  endtask

  task automatic mstep(input logic r, input logic e, input logic l,
                       input logic [SW-1:0] s, input logic [WIDTH-1:0] i,
                       input string nm);
    step(r, e, l, s, i, 1'b1, 1'b0, '0, 1'b0, '0, nm);
  endtask

  vec_t tbl[16];

  initial begin
    for (int k = 0; k < DEPTH; k++) hist.push_back('0);
    m_fill = 0;
    m_sel  = DSEL;

    //          rst   en    load  sel_in i      chk  z      valid sel
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'd0,  4'h0, 0, 4'h0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h1, 1, 4'h0, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h2, 1, 4'h1, 1'b1, 4'd1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'd5,  4'h3, 1, 4'h2, 1'b1, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h4, 1, 4'h0, 1'b0, 4'd5};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h5, 1, 4'h0, 1'b0, 4'd5};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h6, 1, 4'h1, 1'b1, 4'd5};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h7, 1, 4'h2, 1'b1, 4'd5};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'd15, 4'h8, 1, 4'h3, 1'b1, 4'd5};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'h9, 1, 4'h1, 1'b1, 4'd8};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'hA, 1, 4'h2, 1'b1, 4'd8};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'hB, 1, 4'h3, 1'b1, 4'd8};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'hA, 1, 4'hA, 1'b1, 4'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 4'd3,  4'h5, 1, 4'h5, 1'b1, 4'd0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'h7, 1, 4'h0, 1'b0, 4'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'h9, 1, 4'h9, 1'b1, 4'd0};

    for (int n = 0; n < 16; n++) begin
      step(tbl[n].rst, tbl[n].en, tbl[n].load, tbl[n].sel_in, tbl[n].i,
           tbl[n].chk, 1'b1, tbl[n].z, tbl[n].valid, tbl[n].sel,
           $sformatf("tbl%0d", n));
    end

    // Delay 3, fill up, freeze for 4 cycles with the input moving, resume.
    mstep(1'b0, 1'b1, 1'b1, 4'd3, 4'h1, "frz_load");
    for (int n = 2; n <= 6; n++) mstep(1'b0, 1'b1, 1'b0, 4'd0, WIDTH'(n), "frz_fill");
    for (int n = 0; n < 4; n++) mstep(1'b0, 1'b0, 1'b0, 4'd0, WIDTH'(4'hC + n), "frz_hold");
    for (int n = 7; n <= 11; n++) mstep(1'b0, 1'b1, 1'b0, 4'd0, WIDTH'(n), "frz_resume");

    // Reloading the active delay must be invisible.
    mstep(1'b0, 1'b1, 1'b1, 4'd3, 4'h2, "same_sel");
    mstep(1'b0, 1'b1, 1'b0, 4'bx, 4'h3, "same_sel_after");

    // Clamp with full history: Z lags by 8.
    mstep(1'b0, 1'b1, 1'b1, 4'd12, 4'h4, "clamp_load");
    for (int n = 0; n < 10; n++) mstep(1'b0, 1'b1, 1'b0, 4'd0, WIDTH'(n * 3), "clamp_run");

    // Random mix of enable, load (including out-of-range) and rare reset.
    for (int n = 0; n < 400; n++) begin
      logic r, e, l;
      logic [SW-1:0] s;
      r = ($urandom_range(0, 40) == 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 6) == 0);
      s = l ? SW'($urandom_range(0, 15)) : 4'bx;
      mstep(r, e, l, s, WIDTH'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
